button_event: RTL and testbench

//  Consumes the debounced level from button_deb (button_valid, 1 = pressed) and turns it into

---
 rtl/button_event_pkg.sv | 25 ++
 rtl/button_event_ms_ticker.sv | 30 +++
 rtl/button_event.sv | 168 ++++++++++++++++
 tb/tb_button_event.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/button_event_pkg.sv
// Shared definitions for button_event: FSM state encoding and constant width helpers.
package button_event_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_GAP    = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_HELD   = 3'd4
  } state_e;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/button_event_ms_ticker.sv
// Millisecond prescaler: counts 0..CLK_FREQ-1 and flags the last count as the 1 ms tick.
module ms_ticker
  import button_event_pkg::*;
#(
  parameter int CLK_FREQ = 95_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int PW = cnt_w(CLK_FREQ);
  localparam logic [PW-1:0] LAST = PW'(CLK_FREQ - 1);

  logic [PW-1:0] presc_q, presc_d;

  // tick is purely a function of the count so the FSM can use it to decide clr without a loop.
  always_comb begin
    tick    = (presc_q == LAST);
    presc_d = presc_q + 1'b1;
    if (clr || tick) presc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into press/release/click/long-press pulses.
// Optional auto-repeat in HELD is enabled by defining BUTTON_EVENT_REPEAT_EN.
module button_event
  import button_event_pkg::*;
#(
  parameter int CLK_FREQ      = 95_000,
  parameter int LONG_PRESS_MS = 1000,
  parameter int DCLICK_MS     = 300,
  parameter int REPEAT_MS     = 100
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   button_valid,
  output logic   press,
  output logic   release_pulse,
  output logic   short_click,
  output logic   double_click,
  output logic   long_press,
  output logic   repeat_pulse,
  output state_e state_dbg
);

  localparam int MAX_MS = max3(LONG_PRESS_MS, DCLICK_MS, REPEAT_MS);
  localparam int MW     = $clog2(MAX_MS) + 1;
  localparam logic [MW-1:0] LONG_C   = MW'(LONG_PRESS_MS);
  localparam logic [MW-1:0] DCLICK_C = MW'(DCLICK_MS);

  state_e        state_q, state_d;
  logic          btn_q;
  logic [MW-1:0] ms_cnt_q, ms_cnt_d, ms_next;
  logic          tick, clr, restart;
  logic          rise, fall, long_hit, dclick_hit;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          short_q, short_d;
  logic          double_q, double_d;
  logic          long_q, long_d;

  ms_ticker #(.CLK_FREQ(CLK_FREQ)) u_ticker (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  assign rise    = button_valid & ~btn_q;
  assign fall    = ~button_valid & btn_q;
  assign ms_next = (ms_cnt_q == {MW{1'b1}}) ? ms_cnt_q : ms_cnt_q + 1'b1;
  // A timeout fires on the tick that brings ms_cnt to N, so it lands N*CLK_FREQ cycles after entry.
  assign long_hit   = tick && (ms_next == LONG_C);
  assign dclick_hit = tick && (ms_next == DCLICK_C);

`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [MW-1:0] REPEAT_C = MW'(REPEAT_MS);
  logic repeat_q, repeat_d, repeat_hit;
  assign repeat_hit = tick && (ms_next == REPEAT_C);
`endif

  // Edges are tested before timeouts in every state, so an edge wins a same-cycle tie.
  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    double_d  = 1'b0;
    long_d    = 1'b0;
    restart   = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
    repeat_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          state_d = ST_PRESS1;
        end
      end
      ST_PRESS1: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = ST_GAP;
        end else if (long_hit) begin
          long_d  = 1'b1;
          state_d = ST_HELD;
        end
      end
      ST_GAP: begin
        if (rise) begin
          press_d  = 1'b1;
          double_d = 1'b1;
          state_d  = ST_PRESS2;
        end else if (dclick_hit) begin
          short_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_PRESS2: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (long_hit) begin
          long_d  = 1'b1;
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = ST_IDLE;
        end
`ifdef BUTTON_EVENT_REPEAT_EN
        else if (repeat_hit) begin
          repeat_d = 1'b1;
          restart  = 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    clr      = (state_d != state_q) | restart;
    ms_cnt_d = ms_cnt_q;
    if (clr)       ms_cnt_d = '0;
    else if (tick) ms_cnt_d = ms_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      btn_q     <= 1'b0;
      ms_cnt_q  <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      btn_q     <= button_valid;
      ms_cnt_q  <= ms_cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      double_q  <= double_d;
      long_q    <= long_d;
    end
  end

`ifdef BUTTON_EVENT_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) repeat_q <= 1'b0;
    else     repeat_q <= repeat_d;
  end
  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = 1'b0;
`endif

  assign press         = press_q;
  assign release_pulse = release_q;
  assign short_click   = short_q;
  assign double_click  = double_q;
  assign long_press    = long_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with 1 ms = 10 cycles; every cycle's outputs are checked.
module tb_button_event;
  import button_event_pkg::*;

  localparam logic [5:0] E_P = 6'b100000;
  localparam logic [5:0] E_R = 6'b010000;
  localparam logic [5:0] E_S = 6'b001000;
  localparam logic [5:0] E_D = 6'b000100;
  localparam logic [5:0] E_L = 6'b000010;
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [5:0] E_RP = 6'b000001;
`endif

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   button_valid = 1'b0;
  logic   press, release_pulse, short_click, double_click, long_press, repeat_pulse;
  state_e state_dbg;
  logic [5:0] outs;

  int n_tests = 0;
  int n_fail  = 0;
  int          exp_k[$];
  logic [5:0]  exp_v[$];

  button_event #(
    .CLK_FREQ(10), .LONG_PRESS_MS(5), .DCLICK_MS(3), .REPEAT_MS(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .button_valid (button_valid),
    .press        (press),
    .release_pulse(release_pulse),
    .short_click  (short_click),
    .double_click (double_click),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  assign outs = {press, release_pulse, short_click, double_click, long_press, repeat_pulse};

  task automatic check_outs(input string tag, input int cyc, input logic [5:0] obs,
                            input logic [5:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: got %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input state_e exp);
    n_tests++;
    assert (state_dbg === exp) else begin
      n_fail++;
      $error("FAIL %s: state got %0d expected %0d", tag, state_dbg, exp);
    end
  endtask

  // Queue an expected output vector at edge k (1-based) of the next segment.
  task automatic expect_at(input int k, input logic [5:0] v);
    exp_k.push_back(k);
    exp_v.push_back(v);
  endtask

  // Hold button_valid at bv for n edges; outputs must be zero except at queued edges.
  task automatic seg(input int n, input logic bv, input string tag);
    logic [5:0] e;
    for (int i = 1; i <= n; i++) begin
      button_valid = bv;
      @(posedge clk);
      #1;
      e = '0;
      if (exp_k.size() > 0 && exp_k[0] == i) begin
        e = exp_v[0];
        void'(exp_k.pop_front());
        void'(exp_v.pop_front());
      end
      check_outs(tag, i, outs, e);
    end
    exp_k.delete();
    exp_v.delete();
  endtask

  initial begin
    // reset
    rst = 1'b1;
    seg(5, 1'b0, "t1_rst");
    check_state("t1_state_rst", ST_IDLE);
    rst = 1'b0;
    seg(5, 1'b0, "t1_idle");

    // short click
    expect_at(1, E_P);
    seg(20, 1'b1, "t2_hold");
    check_state("t2_state_p1", ST_PRESS1);
    expect_at(1, E_R);
    expect_at(31, E_S);
    seg(40, 1'b0, "t2_gap");
    check_state("t2_state_idle", ST_IDLE);

    // long press
    expect_at(1, E_P);
    expect_at(51, E_L);
    seg(80, 1'b1, "t3_hold");
    check_state("t3_state_held", ST_HELD);
    expect_at(1, E_R);
    seg(40, 1'b0, "t3_rel");

    // double click
    expect_at(1, E_P);
    seg(10, 1'b1, "t4_p1");
    expect_at(1, E_R);
    seg(10, 1'b0, "t4_gap");
    expect_at(1, E_P | E_D);
    seg(10, 1'b1, "t4_p2");
    check_state("t4_state_p2", ST_PRESS2);
    expect_at(1, E_R);
    seg(40, 1'b0, "t4_rel");

    // fall on the long-press tick: release only
    expect_at(1, E_P);
    seg(50, 1'b1, "t7_hold");
    expect_at(1, E_R);
    expect_at(31, E_S);
    seg(40, 1'b0, "t7_rel");

    // second press on the double-click timeout tick: double click wins
    expect_at(1, E_P);
    seg(5, 1'b1, "t8_p1");
    expect_at(1, E_R);
    seg(30, 1'b0, "t8_gap");
    expect_at(1, E_P | E_D);
    seg(5, 1'b1, "t8_p2");
    expect_at(1, E_R);
    seg(40, 1'b0, "t8_rel");

    // reset mid-hold
    expect_at(1, E_P);
    seg(30, 1'b1, "t5_hold");
    rst = 1'b1;
    seg(2, 1'b1, "t5_rst");
    check_state("t5_state_rst", ST_IDLE);
    rst = 1'b0;
    expect_at(1, E_P);
    expect_at(51, E_L);
    seg(60, 1'b1, "t5_after");
    expect_at(1, E_R);
    seg(10, 1'b0, "t5_rel");

    // auto-repeat (absent without the macro)
    expect_at(1, E_P);
    expect_at(51, E_L);
`ifdef BUTTON_EVENT_REPEAT_EN
    expect_at(71, E_RP);
    expect_at(91, E_RP);
`endif
    seg(100, 1'b1, "t6_hold");
    expect_at(1, E_R);
    seg(10, 1'b0, "t6_rel");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
